// File: rtl/alu.sv
// MIPS execute-stage ALU: AND/OR/ADD/SUB/unsigned SLT with Zero and signed Overflow flags.
// Define ALU_STATUS_REG_EN to build the registered status block (aluout_q, zero_q, ovf_sticky).
module alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       alucontrol,
    input  logic [WIDTH-1:0] ALU_operand_1,
    input  logic [WIDTH-1:0] ALU_operand_2,
    output logic [WIDTH-1:0] aluout,
    output logic             Zero,
    output logic             Overflow,
    output logic [WIDTH-1:0] aluout_q,
    output logic             zero_q,
    output logic             ovf_sticky
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;

    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] diff_s;
    logic             a_msb_s;
    logic             b_msb_s;

    assign sum_s   = ALU_operand_1 + ALU_operand_2;
    assign diff_s  = ALU_operand_1 - ALU_operand_2;
    assign a_msb_s = ALU_operand_1[WIDTH-1];
    assign b_msb_s = ALU_operand_2[WIDTH-1];

    // Result, zero and overflow selection for the current operation
    always_comb begin
        aluout   = {WIDTH{1'b0}};
        Zero     = (ALU_operand_1 == ALU_operand_2);
        Overflow = 1'b0;
        case (alucontrol)
            OP_AND: aluout = ALU_operand_1 & ALU_operand_2;
            OP_OR:  aluout = ALU_operand_1 | ALU_operand_2;
            OP_ADD: begin
                aluout   = sum_s;
                // ADD reports on the wrapped sum rather than operand equality
                Zero     = (sum_s == {WIDTH{1'b0}});
                Overflow = (a_msb_s == b_msb_s) && (sum_s[WIDTH-1] != a_msb_s);
            end
            OP_SUB: begin
                aluout   = diff_s;
                Overflow = (a_msb_s != b_msb_s) && (diff_s[WIDTH-1] != a_msb_s);
            end
            OP_SLT: begin
                if (ALU_operand_1 < ALU_operand_2) begin
                    aluout = {{(WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    aluout = {WIDTH{1'b0}};
                end
            end
            default: aluout = {WIDTH{1'b0}};
        endcase
    end

`ifdef ALU_STATUS_REG_EN
    logic [WIDTH-1:0] aluout_r;
    logic             zero_r;
    logic             ovf_sticky_r;

    // Status capture; the overflow flag only ever sets until the next reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aluout_r     <= {WIDTH{1'b0}};
            zero_r       <= 1'b0;
            ovf_sticky_r <= 1'b0;
        end else begin
            aluout_r     <= aluout;
            zero_r       <= Zero;
            ovf_sticky_r <= ovf_sticky_r | Overflow;
        end
    end

    assign aluout_q   = aluout_r;
    assign zero_q     = zero_r;
    assign ovf_sticky = ovf_sticky_r;
`else
    assign aluout_q   = {WIDTH{1'b0}};
    assign zero_q     = 1'b0;
    assign ovf_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_alu.sv
// Randomized self-checking bench for alu (WIDTH=5) against a signed/unsigned integer reference model.
// Registered-output expectations follow ALU_STATUS_REG_EN exactly as the design build does.
module tb_alu;
    localparam int W = 5;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   alucontrol;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [W-1:0] aluout;
    logic         zero;
    logic         overflow;
    logic [W-1:0] aluout_q;
    logic         zero_q;
    logic         ovf_sticky;

    int pass_cnt  = 0;
    int check_cnt = 0;

    // Reference copies of the status registers
    logic [W-1:0] exp_q;
    logic         exp_zq;
    logic         exp_sticky;

    alu #(.WIDTH(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .alucontrol    (alucontrol),
        .ALU_operand_1 (op_a),
        .ALU_operand_2 (op_b),
        .aluout        (aluout),
        .Zero          (zero),
        .Overflow      (overflow),
        .aluout_q      (aluout_q),
        .zero_q        (zero_q),
        .ovf_sticky    (ovf_sticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (ctrl=%b a=%0d b=%0d t=%0t)",
                     tag, obs, exp, alucontrol, op_a, op_b, $time);
        end
    endtask

    // Reference: integer arithmetic, overflow judged by the signed range
    function automatic void model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic z, output logic o);
        int ua, ub, sa, sb, s;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= 16) ? ua - 32 : ua;
        sb = (ub >= 16) ? ub - 32 : ub;
        o  = 1'b0;
        case (c)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: begin
                r = W'((ua + ub) % 32);
                s = sa + sb;
                o = (s > 15) || (s < -16);
            end
            4'b0110: begin
                r = W'((ua - ub + 32) % 32);
                s = sa - sb;
                o = (s > 15) || (s < -16);
            end
            4'b0111: r = (ua < ub) ? W'(1) : W'(0);
            default: r = W'(0);
        endcase
        z = (c == 4'b0010) ? (r == W'(0)) : (a == b);
    endfunction

    task automatic check_regs(input string tag);
`ifdef ALU_STATUS_REG_EN
        check({tag, ".aluout_q"}, 32'(aluout_q), 32'(exp_q));
        check({tag, ".zero_q"}, 32'(zero_q), 32'(exp_zq));
        check({tag, ".ovf_sticky"}, 32'(ovf_sticky), 32'(exp_sticky));
`else
        check({tag, ".aluout_q"}, 32'(aluout_q), 32'd0);
        check({tag, ".zero_q"}, 32'(zero_q), 32'd0);
        check({tag, ".ovf_sticky"}, 32'(ovf_sticky), 32'd0);
`endif
    endtask

    // Drive one operation, check the combinational outputs, then the captured status
    task automatic apply(input string tag, input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        logic z, o;
        alucontrol = c;
        op_a = a;
        op_b = b;
        model(c, a, b, r, z, o);
        #2;
        check({tag, ".aluout"}, 32'(aluout), 32'(r));
        check({tag, ".zero"}, 32'(zero), 32'(z));
        check({tag, ".ovf"}, 32'(overflow), 32'(o));
        @(posedge clk);
        #1;
        exp_q      = r;
        exp_zq     = z;
        exp_sticky = exp_sticky | o;
        check_regs(tag);
    endtask

    initial begin
        logic [3:0] ops [5];
        logic [3:0] c;
        ops[0] = 4'b0000; ops[1] = 4'b0001; ops[2] = 4'b0010; ops[3] = 4'b0110; ops[4] = 4'b0111;

        reset = 1'b1;
        alucontrol = 4'b0010;
        op_a = 5'd15;
        op_b = 5'd1;
        exp_q = '0;
        exp_zq = 1'b0;
        exp_sticky = 1'b0;
        #3;
        check_regs("reset");
        check("reset.comb_aluout", 32'(aluout), 32'd16);
        check("reset.comb_ovf", 32'(overflow), 32'd1);
        @(posedge clk);
        #1;
        check_regs("reset_hold");
        reset = 1'b0;
        @(posedge clk);
        #1;

        apply("add_wrap", 4'b0010, 5'd20, 5'd15);
        apply("add_zero", 4'b0010, 5'd16, 5'd16);
        apply("sub_beq", 4'b0110, 5'd25, 5'd25);
        apply("sub_neg", 4'b0110, 5'd3, 5'd5);
        apply("and", 4'b0000, 5'd12, 5'd10);
        apply("or", 4'b0001, 5'd12, 5'd10);
        apply("slt_0", 4'b0111, 5'd12, 5'd10);
        apply("slt_1", 4'b0111, 5'd3, 5'd20);
        apply("unused_eq", 4'b1111, 5'd7, 5'd7);
        apply("unused_ne", 4'b1111, 5'd7, 5'd9);
        apply("add_ovf", 4'b0010, 5'd15, 5'd1);
        apply("after_ovf1", 4'b0000, 5'd3, 5'd1);
        apply("after_ovf2", 4'b0010, 5'd1, 5'd2);
        apply("sub_ovf", 4'b0110, 5'd16, 5'd1);

        // Mid-cycle asynchronous reset must clear the status immediately
        #3;
        reset = 1'b1;
        #1;
        exp_q = '0;
        exp_zq = 1'b0;
        exp_sticky = 1'b0;
        check_regs("mid_reset");
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        apply("post_reset", 4'b0001, 5'd5, 5'd10);

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                c = 4'($urandom_range(0, 15));
            end else begin
                c = ops[$urandom_range(0, 4)];
            end
            apply("rand", c, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got %0d checks expected completion", check_cnt);
        $fatal(1, "timeout");
    end
endmodule
